othello_turn_ctrl: RTL and testbench

Game-flow controller for the Othello board datapath. It alternates turns, requests a mobility scan for the side to move, and hands player moves to the legality/flip engine. It detects passes and game end. At game end it sequences the stone-counting (grade) engine, then latches the final scores and the winner for the display and VGA logic.

---
 rtl/othello_turn_if.sv | 51 +++++
 rtl/othello_turn_ctrl.sv | 170 +++++++++++++++++
 tb/tb_othello_turn_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/othello_turn_if.sv
// Handshake bundle between the Othello turn controller and its environment
// (player input, mobility scanner, legality/flip engine, grade engine).
interface othello_turn_if;
    localparam int unsigned COORD_W = 3;
    localparam int unsigned SCORE_W = 6;

    logic               i_start;
    logic               i_move_valid;
    logic [COORD_W-1:0] i_move_row;
    logic [COORD_W-1:0] i_move_col;
    logic               o_move_ready;
    logic               o_mob_start;
    logic               i_mob_done;
    logic               i_mob_any;
    logic               o_chk_start;
    logic [COORD_W-1:0] o_chk_row;
    logic [COORD_W-1:0] o_chk_col;
    logic               i_chk_done;
    logic               i_chk_legal;
    logic               o_grade_start;
    logic               i_grade_done;
    logic [SCORE_W-1:0] i_score_black;
    logic [SCORE_W-1:0] i_score_white;
    logic               o_player;
    logic               o_illegal;
    logic [SCORE_W-1:0] o_score_black;
    logic [SCORE_W-1:0] o_score_white;
    logic [1:0]         o_winner;
    logic               o_game_over;
    logic               o_error;

    // Environment side: drives requests/results, observes controller state
    modport master (
        output i_start, i_move_valid, i_move_row, i_move_col,
        output i_mob_done, i_mob_any, i_chk_done, i_chk_legal,
        output i_grade_done, i_score_black, i_score_white,
        input  o_move_ready, o_mob_start, o_chk_start, o_chk_row, o_chk_col,
        input  o_grade_start, o_player, o_illegal, o_score_black, o_score_white,
        input  o_winner, o_game_over, o_error
    );

    // Controller side
    modport slave (
        input  i_start, i_move_valid, i_move_row, i_move_col,
        input  i_mob_done, i_mob_any, i_chk_done, i_chk_legal,
        input  i_grade_done, i_score_black, i_score_white,
        output o_move_ready, o_mob_start, o_chk_start, o_chk_row, o_chk_col,
        output o_grade_start, o_player, o_illegal, o_score_black, o_score_white,
        output o_winner, o_game_over, o_error
    );
endinterface

// File: rtl/othello_turn_ctrl.sv
// Othello game-flow controller: alternates turns, requests mobility scans,
// hands moves to the check/flip engine, detects passes and game end, then
// runs the grade engine and latches scores and winner.
module othello_turn_ctrl #(
    parameter bit          FIRST_PLAYER = 1'b1,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    othello_turn_if.slave bus
);
    localparam int unsigned WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned MOVE_W     = 6;
    localparam int unsigned MOVES_FULL = 60;
    localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [MOVE_W-1:0] MOVES_LAST = MOVE_W'(MOVES_FULL - 1);
    localparam logic [MOVE_W-1:0] MOVES_MAX  = MOVE_W'(MOVES_FULL);
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_BLACK = 2'b01;
    localparam logic [1:0] WIN_WHITE = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_MOB, S_MOB_WAIT, S_WAIT_MOVE, S_CHK,
        S_CHK_WAIT, S_GRADE, S_GRADE_WAIT, S_OVER
    } state_t;

    state_t              state_q;
    logic                player_q;
    logic                pass_q;
    logic [MOVE_W-1:0]   move_cnt_q;
    logic [WD_W-1:0]     wd_q;
    logic [2:0]          chk_row_q;
    logic [2:0]          chk_col_q;
    logic                illegal_q;
    logic [5:0]          score_b_q;
    logic [5:0]          score_w_q;
    logic [1:0]          winner_q;
    logic                error_q;
    logic                wd_expire_c;

    // Watchdog fires on the TIMEOUT-th cycle spent in a wait state without done
    assign wd_expire_c = (wd_q == WD_LAST);

    // Game sequencer with all state and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            player_q   <= FIRST_PLAYER;
            pass_q     <= 1'b0;
            move_cnt_q <= '0;
            wd_q       <= '0;
            chk_row_q  <= '0;
            chk_col_q  <= '0;
            illegal_q  <= 1'b0;
            score_b_q  <= '0;
            score_w_q  <= '0;
            winner_q   <= WIN_NONE;
            error_q    <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (bus.i_start) begin
                        player_q   <= FIRST_PLAYER;
                        pass_q     <= 1'b0;
                        move_cnt_q <= '0;
                        score_b_q  <= '0;
                        score_w_q  <= '0;
                        winner_q   <= WIN_NONE;
                        error_q    <= 1'b0;
                        state_q    <= S_MOB;
                    end
                end
                S_MOB: begin
                    wd_q    <= '0;
                    state_q <= S_MOB_WAIT;
                end
                S_MOB_WAIT: begin
                    if (bus.i_mob_done) begin
                        if (bus.i_mob_any) begin
                            pass_q  <= 1'b0;
                            state_q <= S_WAIT_MOVE;
                        end else if (pass_q) begin
                            state_q <= S_GRADE;
                        end else begin
                            pass_q   <= 1'b1;
                            player_q <= ~player_q;
                            state_q  <= S_MOB;
                        end
                    end else if (wd_expire_c) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_WAIT_MOVE: begin
                    if (bus.i_move_valid) begin
                        chk_row_q <= bus.i_move_row;
                        chk_col_q <= bus.i_move_col;
                        state_q   <= S_CHK;
                    end
                end
                S_CHK: begin
                    wd_q    <= '0;
                    state_q <= S_CHK_WAIT;
                end
                S_CHK_WAIT: begin
                    if (bus.i_chk_done) begin
                        if (bus.i_chk_legal) begin
                            if (move_cnt_q != MOVES_MAX) begin
                                move_cnt_q <= move_cnt_q + MOVE_W'(1);
                            end
                            player_q <= ~player_q;
                            state_q  <= (move_cnt_q == MOVES_LAST) ? S_GRADE : S_MOB;
                        end else begin
                            illegal_q <= 1'b1;
                            state_q   <= S_WAIT_MOVE;
                        end
                    end else if (wd_expire_c) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_GRADE: begin
                    wd_q    <= '0;
                    state_q <= S_GRADE_WAIT;
                end
                S_GRADE_WAIT: begin
                    if (bus.i_grade_done) begin
                        score_b_q <= bus.i_score_black;
                        score_w_q <= bus.i_score_white;
                        if (bus.i_score_black > bus.i_score_white) begin
                            winner_q <= WIN_BLACK;
                        end else if (bus.i_score_white > bus.i_score_black) begin
                            winner_q <= WIN_WHITE;
                        end else begin
                            winner_q <= WIN_DRAW;
                        end
                        state_q <= S_OVER;
                    end else if (wd_expire_c) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes and levels decoded from the registered state only
    assign bus.o_move_ready  = (state_q == S_WAIT_MOVE);
    assign bus.o_mob_start   = (state_q == S_MOB);
    assign bus.o_chk_start   = (state_q == S_CHK);
    assign bus.o_grade_start = (state_q == S_GRADE);
    assign bus.o_game_over   = (state_q == S_OVER);
    assign bus.o_chk_row     = chk_row_q;
    assign bus.o_chk_col     = chk_col_q;
    assign bus.o_player      = player_q;
    assign bus.o_illegal     = illegal_q;
    assign bus.o_score_black = score_b_q;
    assign bus.o_score_white = score_w_q;
    assign bus.o_winner      = winner_q;
    assign bus.o_error       = error_q;
endmodule

// File: tb/tb_othello_turn_ctrl.sv
// Bench for othello_turn_ctrl: drives randomized games through engine stubs
// and compares against a game-rule model (side to move, move count, passes).
module tb_othello_turn_ctrl;
    localparam int unsigned TO = 8;
    localparam int W_MOB = 0, W_CHK = 1, W_GRADE = 2, W_READY = 3;

    logic clk;
    logic rst_n;
    othello_turn_if bus ();

    othello_turn_ctrl #(.FIRST_PLAYER(1'b1), .TIMEOUT(TO)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_mob = 0, n_chk = 0, n_grade = 0, n_ill = 0;

    // Reference game model
    bit exp_player;
    int exp_moves;
    bit exp_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_mob_start === 1'b1)   n_mob++;
        if (bus.o_chk_start === 1'b1)   n_chk++;
        if (bus.o_grade_start === 1'b1) n_grade++;
        if (bus.o_illegal === 1'b1)     n_ill++;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [1:0] ref_winner(input int b, input int w);
        if (b > w) return 2'b01;
        if (w > b) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic sig_of(input int which);
        case (which)
            W_MOB:   return bus.o_mob_start;
            W_CHK:   return bus.o_chk_start;
            W_GRADE: return bus.o_grade_start;
            default: return bus.o_move_ready;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sig_of(which) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic start_game();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        exp_player = 1'b1;
        exp_moves  = 0;
        exp_pass   = 1'b0;
    endtask

    task automatic mob_scan(input bit any, input int lat, output bit ok);
        wait_sig(W_MOB, ok);
        if (!ok) return;
        repeat (lat) tick();
        bus.i_mob_done = 1'b1;
        bus.i_mob_any  = any;
        tick();
        bus.i_mob_done = 1'b0;
        bus.i_mob_any  = 1'b0;
    endtask

    task automatic submit_move(input logic [2:0] r, input logic [2:0] c, input bit legal,
                               input int lat, output bit ok);
        wait_sig(W_READY, ok);
        if (!ok) return;
        bus.i_move_valid = 1'b1;
        bus.i_move_row   = r;
        bus.i_move_col   = c;
        tick();
        bus.i_move_valid = 1'b0;
        wait_sig(W_CHK, ok);
        if (!ok) return;
        repeat (lat) tick();
        bus.i_chk_done  = 1'b1;
        bus.i_chk_legal = legal;
        tick();
        bus.i_chk_done  = 1'b0;
        bus.i_chk_legal = 1'b0;
    endtask

    task automatic grade_run(input logic [5:0] b, input logic [5:0] w, input int lat, output bit ok);
        wait_sig(W_GRADE, ok);
        if (!ok) return;
        repeat (lat) tick();
        bus.i_grade_done  = 1'b1;
        bus.i_score_black = b;
        bus.i_score_white = w;
        tick();
        bus.i_grade_done  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_start = 0; bus.i_move_valid = 0; bus.i_move_row = 0; bus.i_move_col = 0;
        bus.i_mob_done = 0; bus.i_mob_any = 0; bus.i_chk_done = 0; bus.i_chk_legal = 0;
        bus.i_grade_done = 0; bus.i_score_black = 0; bus.i_score_white = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.o_player !== 1'b1) $display("FAIL reset_player: got %b want 1", bus.o_player); else n_pass++;
        n_checks++; if ({bus.o_move_ready, bus.o_game_over, bus.o_error} !== 3'b000) $display("FAIL reset_levels: got %b want 000", {bus.o_move_ready, bus.o_game_over, bus.o_error}); else n_pass++;
        n_checks++; if ({bus.o_winner, bus.o_score_black, bus.o_score_white} !== 14'd0) $display("FAIL reset_scores: got %h want 0", {bus.o_winner, bus.o_score_black, bus.o_score_white}); else n_pass++;
        n_checks++; if ({bus.o_chk_row, bus.o_chk_col} !== 6'd0) $display("FAIL reset_coords: got %h want 0", {bus.o_chk_row, bus.o_chk_col}); else n_pass++;
        n_checks++; if ({bus.o_mob_start, bus.o_chk_start, bus.o_grade_start, bus.o_illegal} !== 4'b0) $display("FAIL reset_pulses: got %b want 0000", {bus.o_mob_start, bus.o_chk_start, bus.o_grade_start, bus.o_illegal}); else n_pass++;
        // Stray done/move strobes while idle must not move the controller
        bus.i_mob_done = 1; bus.i_chk_done = 1; bus.i_grade_done = 1; bus.i_move_valid = 1;
        repeat (3) tick();
        bus.i_mob_done = 0; bus.i_chk_done = 0; bus.i_grade_done = 0; bus.i_move_valid = 0;
        tick();
        n_checks++; if ((n_mob + n_chk + n_grade) != 0 || bus.o_game_over !== 1'b0 || bus.o_winner !== 2'b00) $display("FAIL idle_ignore: pulses %0d go %b win %b want 0 0 00", n_mob + n_chk + n_grade, bus.o_game_over, bus.o_winner); else n_pass++;
    endtask

    task automatic test_normal_move();
        bit ok;
        int m0, c0;
        m0 = n_mob; c0 = n_chk;
        start_game();
        mob_scan(1'b1, $urandom_range(1, 4), ok);
        n_checks++; if (!ok) $display("FAIL nm_mob_seen: got none want pulse"); else n_pass++;
        n_checks++; if (n_mob - m0 != 1) $display("FAIL nm_mob_count: got %0d want 1", n_mob - m0); else n_pass++;
        n_checks++; if (bus.o_move_ready !== 1'b1 || bus.o_player !== exp_player) $display("FAIL nm_ready: ready %b player %b want 1 %b", bus.o_move_ready, bus.o_player, exp_player); else n_pass++;
        // Start while mid-game is ignored
        bus.i_start = 1'b1; tick(); bus.i_start = 1'b0; tick();
        n_checks++; if (n_mob - m0 != 1 || bus.o_move_ready !== 1'b1) $display("FAIL nm_start_ignored: mobs %0d ready %b want 1 1", n_mob - m0, bus.o_move_ready); else n_pass++;
        bus.i_move_valid = 1'b1; bus.i_move_row = 3'd2; bus.i_move_col = 3'd3;
        tick();
        bus.i_move_valid = 1'b0;
        n_checks++; if (bus.o_chk_start !== 1'b1 || bus.o_move_ready !== 1'b0) $display("FAIL nm_chk_pulse: chk %b ready %b want 1 0", bus.o_chk_start, bus.o_move_ready); else n_pass++;
        // Done in the pulse cycle is ignored
        bus.i_chk_done = 1'b1; bus.i_chk_legal = 1'b1;
        tick();
        bus.i_chk_done = 1'b0; bus.i_chk_legal = 1'b0;
        n_checks++; if (bus.o_chk_row !== 3'd2 || bus.o_chk_col !== 3'd3) $display("FAIL nm_coords: got %0d,%0d want 2,3", bus.o_chk_row, bus.o_chk_col); else n_pass++;
        // Move strobe outside WAIT_MOVE is dropped
        bus.i_move_valid = 1'b1; bus.i_move_row = 3'd7; bus.i_move_col = 3'd7;
        tick();
        bus.i_move_valid = 1'b0;
        tick(); tick();
        n_checks++; if (bus.o_player !== 1'b1 || bus.o_mob_start !== 1'b0 || n_mob - m0 != 1) $display("FAIL nm_early_done: player %b mob %b want 1 0", bus.o_player, bus.o_mob_start); else n_pass++;
        tick();
        bus.i_chk_done = 1'b1; bus.i_chk_legal = 1'b1;
        tick();
        bus.i_chk_done = 1'b0; bus.i_chk_legal = 1'b0;
        exp_moves++; exp_player = ~exp_player;
        n_checks++; if (bus.o_mob_start !== 1'b1 || bus.o_player !== exp_player) $display("FAIL nm_after_move: mob %b player %b want 1 %b", bus.o_mob_start, bus.o_player, exp_player); else n_pass++;
        n_checks++; if (bus.o_chk_row !== 3'd2 || bus.o_chk_col !== 3'd3 || n_chk - c0 != 1) $display("FAIL nm_coords_hold: got %0d,%0d chks %0d want 2,3 1", bus.o_chk_row, bus.o_chk_col, n_chk - c0); else n_pass++;
    endtask

    task automatic test_illegal();
        bit ok;
        int i0;
        mob_scan(1'b1, $urandom_range(1, 5), ok);
        exp_pass = 1'b0;
        i0 = n_ill;
        submit_move(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, $urandom_range(1, 5), ok);
        n_checks++; if (!ok) $display("FAIL il_handshake: got none want pulses"); else n_pass++;
        n_checks++; if (bus.o_illegal !== 1'b1 || bus.o_move_ready !== 1'b1) $display("FAIL il_pulse: illegal %b ready %b want 1 1", bus.o_illegal, bus.o_move_ready); else n_pass++;
        n_checks++; if (bus.o_player !== exp_player) $display("FAIL il_player: got %b want %b", bus.o_player, exp_player); else n_pass++;
        tick();
        n_checks++; if (bus.o_illegal !== 1'b0 || n_ill - i0 != 1) $display("FAIL il_once: illegal %b count %0d want 0 1", bus.o_illegal, n_ill - i0); else n_pass++;
        submit_move(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, $urandom_range(1, 5), ok);
        exp_moves++; exp_player = ~exp_player;
        n_checks++; if (bus.o_player !== exp_player || bus.o_mob_start !== 1'b1) $display("FAIL il_then_legal: player %b mob %b want %b 1", bus.o_player, bus.o_mob_start, exp_player); else n_pass++;
    endtask

    task automatic test_pass();
        bit ok;
        int g0;
        logic [5:0] b, w;
        g0 = n_grade;
        mob_scan(1'b0, $urandom_range(1, 5), ok);
        exp_pass = 1'b1; exp_player = ~exp_player;
        n_checks++; if (bus.o_player !== exp_player || bus.o_mob_start !== 1'b1) $display("FAIL ps_single: player %b mob %b want %b 1", bus.o_player, bus.o_mob_start, exp_player); else n_pass++;
        mob_scan(1'b1, $urandom_range(1, 5), ok);
        exp_pass = 1'b0;
        submit_move(3'd4, 3'd5, 1'b1, $urandom_range(1, 5), ok);
        exp_moves++; exp_player = ~exp_player;
        mob_scan(1'b0, $urandom_range(1, 5), ok);
        exp_pass = 1'b1; exp_player = ~exp_player;
        n_checks++; if (bus.o_mob_start !== 1'b1 || bus.o_grade_start !== 1'b0 || bus.o_player !== exp_player) $display("FAIL ps_cleared: mob %b grade %b player %b want 1 0 %b", bus.o_mob_start, bus.o_grade_start, bus.o_player, exp_player); else n_pass++;
        mob_scan(1'b0, $urandom_range(1, 5), ok);
        n_checks++; if (bus.o_grade_start !== 1'b1 || bus.o_player !== exp_player) $display("FAIL ps_double: grade %b player %b want 1 %b", bus.o_grade_start, bus.o_player, exp_player); else n_pass++;
        b = 6'($urandom_range(0, 63)); w = 6'($urandom_range(0, 63));
        grade_run(b, w, $urandom_range(1, 5), ok);
        n_checks++; if (bus.o_winner !== ref_winner(b, w) || bus.o_game_over !== 1'b1) $display("FAIL ps_winner: win %b over %b want %b 1", bus.o_winner, bus.o_game_over, ref_winner(b, w)); else n_pass++;
        n_checks++; if (bus.o_score_black !== b || bus.o_score_white !== w || n_grade - g0 != 1) $display("FAIL ps_scores: got %0d/%0d grades %0d want %0d/%0d 1", bus.o_score_black, bus.o_score_white, n_grade - g0, b, w); else n_pass++;
    endtask

    task automatic test_board_full();
        bit ok, any;
        int m0, scans, guard;
        m0 = n_mob; scans = 0; guard = 0;
        start_game();
        while (exp_moves < 60 && guard < 400) begin
            guard++;
            any = !(exp_pass == 1'b0 && $urandom_range(0, 7) == 0);
            mob_scan(any, $urandom_range(1, 5), ok);
            scans++;
            if (!ok) begin
                n_checks++; $display("FAIL bf_mob_seen: got none want pulse at move %0d", exp_moves);
                break;
            end
            if (!any) begin
                exp_pass = 1'b1; exp_player = ~exp_player;
                n_checks++; if (bus.o_player !== exp_player) $display("FAIL bf_pass_player: got %b want %b", bus.o_player, exp_player); else n_pass++;
                continue;
            end
            exp_pass = 1'b0;
            n_checks++; if (bus.o_player !== exp_player || bus.o_move_ready !== 1'b1) $display("FAIL bf_turn: player %b ready %b want %b 1", bus.o_player, bus.o_move_ready, exp_player); else n_pass++;
            if ($urandom_range(0, 3) == 0) begin
                submit_move(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, $urandom_range(1, 5), ok);
                n_checks++; if (bus.o_illegal !== 1'b1) $display("FAIL bf_illegal: got %b want 1", bus.o_illegal); else n_pass++;
            end
            submit_move(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, $urandom_range(1, 5), ok);
            exp_moves++; exp_player = ~exp_player;
        end
        n_checks++; if (bus.o_grade_start !== 1'b1 || bus.o_mob_start !== 1'b0) $display("FAIL bf_full_grade: grade %b mob %b want 1 0", bus.o_grade_start, bus.o_mob_start); else n_pass++;
        n_checks++; if (bus.o_player !== exp_player || n_mob - m0 != scans) $display("FAIL bf_scans: player %b scans %0d want %b %0d", bus.o_player, n_mob - m0, exp_player, scans); else n_pass++;
        grade_run(6'd40, 6'd24, $urandom_range(1, 5), ok);
        n_checks++; if (bus.o_winner !== 2'b01 || bus.o_game_over !== 1'b1) $display("FAIL bf_winner: win %b over %b want 01 1", bus.o_winner, bus.o_game_over); else n_pass++;
        n_checks++; if (bus.o_score_black !== 6'd40 || bus.o_score_white !== 6'd24) $display("FAIL bf_scores: got %0d/%0d want 40/24", bus.o_score_black, bus.o_score_white); else n_pass++;
    endtask

    task automatic test_grade_results();
        bit ok;
        logic [5:0] b, w;
        for (int g = 0; g < 4; g++) begin
            case (g)
                0: begin b = 6'd32; w = 6'd32; end
                1: begin b = 6'd10; w = 6'd50; end
                default: begin b = 6'($urandom_range(0, 63)); w = 6'($urandom_range(0, 63)); end
            endcase
            start_game();
            n_checks++; if (bus.o_score_black !== 6'd0 || bus.o_winner !== 2'b00 || bus.o_game_over !== 1'b0) $display("FAIL gr_cleared: sb %0d win %b over %b want 0 00 0", bus.o_score_black, bus.o_winner, bus.o_game_over); else n_pass++;
            mob_scan(1'b0, $urandom_range(1, 5), ok);
            mob_scan(1'b0, $urandom_range(1, 5), ok);
            grade_run(b, w, $urandom_range(1, 5), ok);
            n_checks++; if (bus.o_winner !== ref_winner(b, w) || bus.o_score_black !== b || bus.o_score_white !== w) $display("FAIL gr_winner: win %b sc %0d/%0d want %b %0d/%0d", bus.o_winner, bus.o_score_black, bus.o_score_white, ref_winner(b, w), b, w); else n_pass++;
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        start_game();
        mob_scan(1'b1, $urandom_range(1, 5), ok);
        wait_sig(W_READY, ok);
        bus.i_move_valid = 1'b1; bus.i_move_row = 3'd1; bus.i_move_col = 3'd1;
        tick();
        bus.i_move_valid = 1'b0;
        n_checks++; if (bus.o_chk_start !== 1'b1) $display("FAIL wd_chk_pulse: got %b want 1", bus.o_chk_start); else n_pass++;
        repeat (TO) tick();
        n_checks++; if (bus.o_error !== 1'b0) $display("FAIL wd_not_yet: got %b want 0", bus.o_error); else n_pass++;
        tick();
        n_checks++; if (bus.o_error !== 1'b1 || bus.o_move_ready !== 1'b0 || bus.o_game_over !== 1'b0) $display("FAIL wd_fire: err %b ready %b over %b want 1 0 0", bus.o_error, bus.o_move_ready, bus.o_game_over); else n_pass++;
        start_game();
        n_checks++; if (bus.o_error !== 1'b0 || bus.o_mob_start !== 1'b1) $display("FAIL wd_restart: err %b mob %b want 0 1", bus.o_error, bus.o_mob_start); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int g0;
        mob_scan(1'b0, $urandom_range(1, 5), ok);
        exp_pass = 1'b1; exp_player = ~exp_player;
        mob_scan(1'b1, $urandom_range(1, 5), ok);
        exp_pass = 1'b0;
        submit_move(3'd5, 3'd6, 1'b1, $urandom_range(1, 5), ok);
        exp_player = ~exp_player;
        mob_scan(1'b0, $urandom_range(1, 5), ok);
        exp_pass = 1'b1; exp_player = ~exp_player;
        mob_scan(1'b0, $urandom_range(1, 5), ok);
        wait_sig(W_GRADE, ok);
        n_checks++; if (!ok || bus.o_player !== exp_player || bus.o_chk_row !== 3'd5) $display("FAIL rm_setup: grade %b player %b row %0d want 1 %b 5", ok, bus.o_player, bus.o_chk_row, exp_player); else n_pass++;
        tick(); tick();
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_player !== 1'b1 || bus.o_chk_row !== 3'd0 || bus.o_chk_col !== 3'd0) $display("FAIL rm_async: player %b coords %0d,%0d want 1 0,0", bus.o_player, bus.o_chk_row, bus.o_chk_col); else n_pass++;
        n_checks++; if ({bus.o_grade_start, bus.o_mob_start, bus.o_move_ready, bus.o_game_over, bus.o_error, bus.o_winner} !== 7'd0) $display("FAIL rm_levels: got %b want 0000000", {bus.o_grade_start, bus.o_mob_start, bus.o_move_ready, bus.o_game_over, bus.o_error, bus.o_winner}); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        g0 = n_grade;
        bus.i_grade_done = 1'b1; bus.i_score_black = 6'd50; bus.i_score_white = 6'd3;
        tick();
        bus.i_grade_done = 1'b0;
        tick();
        n_checks++; if (bus.o_winner !== 2'b00 || bus.o_score_black !== 6'd0 || bus.o_game_over !== 1'b0 || n_grade != g0) $display("FAIL rm_late_done: win %b sb %0d over %b want 00 0 0", bus.o_winner, bus.o_score_black, bus.o_game_over); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_normal_move();
        test_illegal();
        test_pass();
        test_board_full();
        test_grade_results();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
